// File: rtl/game_turn_arbiter_if.sv
// Bundles the arbiter's start, player, counter read-back and counter-drive
// signals. The slave modport is the arbiter's view; the master modport is the
// view of whatever surrounds it (players, counter, test environment).
interface game_turn_arbiter_if #(
  parameter int WIDTH  = 2,
  parameter int MOVE_W = 8
);
  logic              start_i;
  logic [WIDTH-1:0]  start_val_i;
  logic              req_a_i;
  logic [1:0]        ctrl_a_i;
  logic              req_b_i;
  logic [1:0]        ctrl_b_i;
  logic [WIDTH-1:0]  count_i;
  logic              gameover_i;
  logic [1:0]        ctrl_o;
  logic              init_o;
  logic [WIDTH-1:0]  val_o;
  logic              gnt_a_o;
  logic              gnt_b_o;
  logic [MOVE_W-1:0] moves_a_o;
  logic [MOVE_W-1:0] moves_b_o;
  logic              busy_o;

  modport slave (
    input  start_i, start_val_i, req_a_i, ctrl_a_i, req_b_i, ctrl_b_i,
           count_i, gameover_i,
    output ctrl_o, init_o, val_o, gnt_a_o, gnt_b_o, moves_a_o, moves_b_o,
           busy_o
  );

  modport master (
    output start_i, start_val_i, req_a_i, ctrl_a_i, req_b_i, ctrl_b_i,
           count_i, gameover_i,
    input  ctrl_o, init_o, val_o, gnt_a_o, gnt_b_o, moves_a_o, moves_b_o,
           busy_o
  );
endinterface

// File: rtl/game_turn_arbiter.sv
// Two-player turn arbiter sitting in front of the shared game counter.
// Sequences a match IDLE -> LOAD -> PLAY -> DONE, grants at most one move per
// cycle and keeps the counter frozen (reload of its own value) otherwise.
// Build option: define GAME_ARB_PRIORITY_EN for fixed priority (A beats B);
// leave it undefined for round-robin arbitration.
module game_turn_arbiter #(
  parameter int WIDTH  = 2,
  parameter int MOVE_W = 8
) (
  input logic               clk,
  input logic               rst,
  game_turn_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  localparam logic [MOVE_W-1:0] MOVE_MAX = '1;
  localparam logic [MOVE_W-1:0] MOVE_ONE = 1;

  state_t            state_q, state_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [1:0]        cmd_ctrl_q, cmd_ctrl_d;
  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;
  logic [MOVE_W-1:0] moves_a_q, moves_a_d;
  logic [MOVE_W-1:0] moves_b_q, moves_b_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  start_val_q, start_val_d;
  logic              elig_a, elig_b;
  logic              pick_a, pick_b;

  // A player granted last cycle sits out this edge, so a request held one
  // cycle past its grant cannot be granted twice.
  assign elig_a = bus.req_a_i & ~gnt_a_q;
  assign elig_b = bus.req_b_i & ~gnt_b_q;

`ifdef GAME_ARB_PRIORITY_EN
  assign pick_a = elig_a;
`else
  // last_q: 1 = B won the last contested edge, so A goes first after reset.
  logic last_q, last_d;
  assign pick_a = elig_a & (~elig_b | last_q);
`endif
  assign pick_b = elig_b & ~pick_a;

  // Counter drive: reload the current count unless a move command is pending.
  assign bus.init_o    = ~cmd_valid_q;
  assign bus.ctrl_o    = cmd_ctrl_q;
  assign bus.val_o     = (state_q == LOAD) ? start_val_q : bus.count_i;
  assign bus.gnt_a_o   = gnt_a_q;
  assign bus.gnt_b_o   = gnt_b_q;
  assign bus.moves_a_o = moves_a_q;
  assign bus.moves_b_o = moves_b_q;
  assign bus.busy_o    = busy_q;

  // Next-state and next-register values for the match sequencer.
  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves a
    // value unassigned, which would infer a latch.
    state_d     = state_q;
    cmd_valid_d = 1'b0;
    cmd_ctrl_d  = cmd_ctrl_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    moves_a_d   = moves_a_q;
    moves_b_d   = moves_b_q;
    start_val_d = start_val_q;
`ifndef GAME_ARB_PRIORITY_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          state_d     = LOAD;
          start_val_d = bus.start_val_i;
        end
      end
      LOAD: begin
        moves_a_d = '0;
        moves_b_d = '0;
        state_d   = PLAY;
      end
      PLAY: begin
        if (bus.start_i) begin
          // Abort: the command already issued still executes this edge.
          state_d     = LOAD;
          start_val_d = bus.start_val_i;
        end else if (bus.gameover_i) begin
          state_d = DONE;
        end else if (pick_a) begin
          cmd_valid_d = 1'b1;
          cmd_ctrl_d  = bus.ctrl_a_i;
          gnt_a_d     = 1'b1;
          if (moves_a_q != MOVE_MAX) moves_a_d = moves_a_q + MOVE_ONE;
`ifndef GAME_ARB_PRIORITY_EN
          if (elig_b) last_d = 1'b0;
`endif
        end else if (pick_b) begin
          cmd_valid_d = 1'b1;
          cmd_ctrl_d  = bus.ctrl_b_i;
          gnt_b_d     = 1'b1;
          if (moves_b_q != MOVE_MAX) moves_b_d = moves_b_q + MOVE_ONE;
`ifndef GAME_ARB_PRIORITY_EN
          if (elig_a) last_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == PLAY);
  end

  // State and all registered outputs, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_ctrl_q  <= 2'd0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      moves_a_q   <= '0;
      moves_b_q   <= '0;
      busy_q      <= 1'b0;
      start_val_q <= '0;
`ifndef GAME_ARB_PRIORITY_EN
      last_q      <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_ctrl_q  <= cmd_ctrl_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      moves_a_q   <= moves_a_d;
      moves_b_q   <= moves_b_d;
      busy_q      <= busy_d;
      start_val_q <= start_val_d;
`ifndef GAME_ARB_PRIORITY_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule
